digit_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the clock's 7-segment display bank. It owns a one-hot digit-select ring that resets to digit 0 (`...0001`) and rotates through enabled digits at a fixed slot rate, with a dark blanking interval at the start of each slot to suppress ghosting. It sits between the time/date digit registers, which supply packed BCD, and the display pins, which take anode select, segments and decimal point.

---
 rtl/digit_scan_ctrl_pkg.sv | 18 +
 rtl/digit_scan_ctrl_bcd_to_seg7.sv | 11 +
 rtl/digit_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_digit_scan_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment digit scan controller.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DARK = 2'd1,
    ST_SHOW = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment patterns a..g (bit0 = a); non-decimal codes stay blank.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

endpackage

// File: rtl/digit_scan_ctrl_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; the caller registers the result.
module bcd_to_seg7
  import digit_scan_pkg::*;
(
  input  logic [3:0] i_Bcd,
  output logic [6:0] o_Seg
);

  assign o_Seg = SEG7_LUT[i_Bcd];

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scan: one-hot anode ring with a dark blanking
// interval at the start of every slot. All outputs come from registers.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int N_DIG = 6,
  parameter int DIV   = 1000,
  parameter int BLANK = 8
) (
  input  logic                     i_Clk,
  input  logic                     i_pRst,
  input  logic                     i_En,
  input  logic [N_DIG-1:0]         i_DigMask,
  input  logic [4*N_DIG-1:0]       i_Bcd,
  input  logic [N_DIG-1:0]         i_Dp,
  output logic [N_DIG-1:0]         o_DigSel,
  output logic [6:0]               o_Seg,
  output logic                     o_Dp,
  output logic [$clog2(N_DIG)-1:0] o_Idx,
  output logic                     o_Frame
);

  localparam int IW = $clog2(N_DIG);
  localparam int CW = $clog2(DIV);

  scan_state_e      r_state;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;
  logic [N_DIG-1:0] r_ring;

  scan_state_e      w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [IW-1:0]    w_idx_nxt;
  logic [N_DIG-1:0] w_ring_nxt;
  logic [N_DIG-1:0] w_sel_nxt;
  logic             w_frame_nxt;
  logic [3:0]       w_bcd;
  logic [6:0]       w_seg;

  // Priority rotate: first set mask bit at start (or after it when skip_cur), wrapping.
  function automatic logic [IW-1:0] next_idx(input logic [N_DIG-1:0] mask,
                                             input logic [IW-1:0] start,
                                             input logic skip_cur);
    logic [IW-1:0] res;
    logic          found;
    int            j;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      j = int'(start) + k + (skip_cur ? 1 : 0);
      if (j >= N_DIG) j = j - N_DIG;
      if (!found && mask[j]) begin
        res   = IW'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Next-state, prescaler and digit advance.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_frame_nxt = 1'b0;
    if (!i_En || (i_DigMask == '0)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DARK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = next_idx(i_DigMask, r_idx, 1'b0);
        end
        ST_DARK: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CW'(BLANK - 1)) begin
            w_state_nxt = ST_SHOW;
          end else begin
            w_state_nxt = ST_DARK;
          end
        end
        ST_SHOW: begin
          if (r_cnt == CW'(DIV - 1)) begin
            w_state_nxt = ST_DARK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = next_idx(i_DigMask, r_idx, 1'b1);
            w_frame_nxt = (w_idx_nxt <= r_idx);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // The ring only re-seeds when the index actually moves.
  assign w_ring_nxt = (w_idx_nxt == r_idx) ? r_ring
                    : ({{(N_DIG-1){1'b0}}, 1'b1} << w_idx_nxt);
  assign w_sel_nxt  = (w_state_nxt == ST_SHOW) ? (w_ring_nxt & i_DigMask) : '0;
  assign w_bcd      = i_Bcd[{w_idx_nxt, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_Bcd (w_bcd),
    .o_Seg (w_seg)
  );

  // State and output registers.
  always_ff @(posedge i_Clk) begin
    if (i_pRst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_ring   <= {{(N_DIG-1){1'b0}}, 1'b1};
      o_DigSel <= '0;
      o_Seg    <= SEG_BLANK;
      o_Dp     <= 1'b0;
      o_Frame  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_ring   <= w_ring_nxt;
      o_DigSel <= w_sel_nxt;
      o_Seg    <= (|w_sel_nxt) ? w_seg : SEG_BLANK;
      o_Dp     <= (|w_sel_nxt) ? i_Dp[w_idx_nxt] : 1'b0;
      o_Frame  <= w_frame_nxt;
    end
  end

  assign o_Idx = r_idx;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with N_DIG=4, DIV=10, BLANK=2.
module tb_digit_scan_ctrl;

  logic        i_Clk = 1'b0;
  logic        i_pRst;
  logic        i_En;
  logic [3:0]  i_DigMask;
  logic [15:0] i_Bcd;
  logic [3:0]  i_Dp;
  logic [3:0]  o_DigSel;
  logic [6:0]  o_Seg;
  logic        o_Dp;
  logic [1:0]  o_Idx;
  logic        o_Frame;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] bcd;
    logic       dp;
    logic [6:0] seg;
  } dec_vec_t;

  dec_vec_t vecs [16];

  digit_scan_ctrl #(.N_DIG(4), .DIV(10), .BLANK(2)) dut (
    .i_Clk     (i_Clk),
    .i_pRst    (i_pRst),
    .i_En      (i_En),
    .i_DigMask (i_DigMask),
    .i_Bcd     (i_Bcd),
    .i_Dp      (i_Dp),
    .o_DigSel  (o_DigSel),
    .o_Seg     (o_Seg),
    .o_Dp      (o_Dp),
    .o_Idx     (o_Idx),
    .o_Frame   (o_Frame)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_dark(input string name, input logic [1:0] idx);
    chk({name, "_sel"}, 32'(o_DigSel), 32'h0);
    chk({name, "_seg"}, 32'(o_Seg), 32'h0);
    chk({name, "_dp"}, 32'(o_Dp), 32'h0);
    chk({name, "_frame"}, 32'(o_Frame), 32'h0);
    chk({name, "_idx"}, 32'(o_Idx), 32'(idx));
  endtask

  // One full slot: 2 dark cycles, then 8 lit; frame only on the first cycle.
  task automatic check_slot(input logic [3:0] sel, input logic [6:0] seg,
                            input logic [1:0] idx, input logic frame, input logic dp);
    for (int c = 0; c < 10; c++) begin
      step();
      if (c < 2) begin
        chk("slot_dark_sel", 32'(o_DigSel), 32'h0);
        chk("slot_dark_seg", 32'(o_Seg), 32'h0);
      end else begin
        chk("slot_lit_sel", 32'(o_DigSel), 32'(sel));
        chk("slot_lit_seg", 32'(o_Seg), 32'(seg));
        chk("slot_lit_dp", 32'(o_Dp), 32'(dp));
      end
      chk("slot_idx", 32'(o_Idx), 32'(idx));
      chk("slot_frame", 32'(o_Frame), (c == 0) ? 32'(frame) : 32'h0);
    end
  endtask

  initial begin
    vecs[0]  = '{4'h0, 1'b0, 7'h3F};
    vecs[1]  = '{4'h1, 1'b1, 7'h06};
    vecs[2]  = '{4'h2, 1'b0, 7'h5B};
    vecs[3]  = '{4'h3, 1'b1, 7'h4F};
    vecs[4]  = '{4'h4, 1'b0, 7'h66};
    vecs[5]  = '{4'h5, 1'b1, 7'h6D};
    vecs[6]  = '{4'h6, 1'b0, 7'h7D};
    vecs[7]  = '{4'h7, 1'b1, 7'h07};
    vecs[8]  = '{4'h8, 1'b0, 7'h7F};
    vecs[9]  = '{4'h9, 1'b1, 7'h6F};
    vecs[10] = '{4'hA, 1'b0, 7'h00};
    vecs[11] = '{4'hB, 1'b1, 7'h00};
    vecs[12] = '{4'hC, 1'b0, 7'h00};
    vecs[13] = '{4'hD, 1'b1, 7'h00};
    vecs[14] = '{4'hE, 1'b0, 7'h00};
    vecs[15] = '{4'hF, 1'b1, 7'h00};

    i_pRst = 1'b1; i_En = 1'b0; i_DigMask = 4'b0000; i_Bcd = 16'h0000; i_Dp = 4'b0000;

    // 1. reset, then idle with scan disabled
    for (int c = 0; c < 3; c++) step();
    chk_dark("reset", 2'd0);
    i_pRst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_dark("idle_off", 2'd0);
    end

    // 2. all four digits
    i_DigMask = 4'b1111; i_Bcd = 16'h3210; i_En = 1'b1;
    check_slot(4'b0001, 7'h3F, 2'd0, 1'b0, 1'b0);
    check_slot(4'b0010, 7'h06, 2'd1, 1'b0, 1'b0);
    check_slot(4'b0100, 7'h5B, 2'd2, 1'b0, 1'b0);
    check_slot(4'b1000, 7'h4F, 2'd3, 1'b0, 1'b0);
    check_slot(4'b0001, 7'h3F, 2'd0, 1'b1, 1'b0);

    // 3. sparse mask: digits 0 and 2 only
    i_DigMask = 4'b0101;
    check_slot(4'b0100, 7'h5B, 2'd2, 1'b0, 1'b0);
    check_slot(4'b0001, 7'h3F, 2'd0, 1'b1, 1'b0);
    check_slot(4'b0100, 7'h5B, 2'd2, 1'b0, 1'b0);
    check_slot(4'b0001, 7'h3F, 2'd0, 1'b1, 1'b0);

    // 4. empty mask parks in idle, then resumes at the next set bit
    i_DigMask = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      step();
      chk_dark("empty_mask", 2'd0);
    end
    i_DigMask = 4'b0010;
    check_slot(4'b0010, 7'h06, 2'd1, 1'b0, 1'b0);

    // 5. enable dropped in the 4th lit cycle of digit 2
    i_DigMask = 4'b1111;
    step(); chk_dark("en_drop_d0", 2'd2);
    step(); chk_dark("en_drop_d1", 2'd2);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("en_drop_lit_sel", 32'(o_DigSel), 32'h4);
      chk("en_drop_lit_seg", 32'(o_Seg), 32'h5B);
    end
    i_En = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_dark("en_off", 2'd2);
    end
    i_En = 1'b1;
    check_slot(4'b0100, 7'h5B, 2'd2, 1'b0, 1'b0);

    // 6. reset pulsed mid-show of digit 3, then blank code with dp on digit 0
    step(); chk_dark("rst_d0", 2'd3);
    step(); chk_dark("rst_d1", 2'd3);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_lit_sel", 32'(o_DigSel), 32'h8);
    end
    i_pRst = 1'b1;
    step();
    chk_dark("rst_mid", 2'd0);
    i_pRst = 1'b0; i_Bcd = 16'h321A; i_Dp = 4'b0001;
    check_slot(4'b0001, 7'h00, 2'd0, 1'b0, 1'b1);

    // decoder table on a single enabled digit: frame on every advance
    i_DigMask = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      i_Bcd = {12'h321, vecs[i].bcd};
      i_Dp  = {3'b000, vecs[i].dp};
      check_slot(4'b0001, vecs[i].seg, 2'd0, 1'b1, vecs[i].dp);
    end

    // current digit removed mid-show: dark at once, slot still runs to its end
    i_DigMask = 4'b0011; i_Dp = 4'b0000;
    step(); chk("clr_frame", 32'(o_Frame), 32'h0);
    chk("clr_idx", 32'(o_Idx), 32'h1);
    step();
    for (int c = 0; c < 2; c++) begin
      step();
      chk("clr_lit_sel", 32'(o_DigSel), 32'h2);
      chk("clr_lit_seg", 32'(o_Seg), 32'h06);
    end
    i_DigMask = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      step();
      chk_dark("clr_tail", 2'd1);
    end
    step();
    chk("clr_adv_idx", 32'(o_Idx), 32'h0);
    chk("clr_adv_frame", 32'(o_Frame), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
